// File: rtl/hp_tracker.sv
// Player HP state machine feeding the HP bar renderer and the soul sprite flags.
// Optional frame-counted regeneration is built only when HP_REGEN_EN is defined.
module hp_tracker #(
    parameter int unsigned HP_MAX       = 20,
    parameter int unsigned IFRAMES      = 60,
    parameter int unsigned BAR_X0       = 50,
    parameter int unsigned BAR_W        = 100,
    parameter int unsigned REGEN_FRAMES = 120
) (
    input  logic       Pclk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic [4:0] hit_dmg,
    input  logic       heal,
    input  logic [4:0] heal_amt,
    input  logic       revive,
    output logic [5:0] hp,
    output logic [9:0] hp_fill_x,
    output logic       hit_ack,
    output logic       invuln,
    output logic       blink,
    output logic       dead
);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    localparam logic [5:0] HP_FULL   = 6'(HP_MAX);
    localparam logic [7:0] IFR_LOAD  = 8'(IFRAMES);
    localparam logic [9:0] FILL_FULL = 10'(BAR_X0 + BAR_W);

    if (HP_MAX < 1 || HP_MAX > 63 || IFRAMES < 1 || IFRAMES > 255 || REGEN_FRAMES < 1) begin : gBadParams
        $error("hp_tracker: parameter out of legal range");
    end

    state_t     state_q, state_d;
    logic [5:0] hp_q, hp_d;
    logic [7:0] ifr_q, ifr_d;
    logic [1:0] blinkCnt_q, blinkCnt_d;
    logic       blink_q, blink_d;
    logic       ack_q, ack_d;
    logic [9:0] fill_q;

    logic [6:0] healSum;
    logic [5:0] healSat;
    logic [5:0] hitResult;

    // Heal is summed at 7 bits so a large heal_amt cannot wrap past HP_MAX.
    assign healSum   = {1'b0, hp_q} + {2'b00, heal_amt};
    assign healSat   = (healSum > {1'b0, HP_FULL}) ? HP_FULL : healSum[5:0];
    assign hitResult = ({1'b0, hit_dmg} >= hp_q) ? 6'd0 : hp_q - {1'b0, hit_dmg};

`ifdef HP_REGEN_EN
    localparam logic [15:0] REGEN_LAST = 16'(REGEN_FRAMES - 1);
    logic [15:0] regen_q, regen_d;
`endif

    always_comb begin
        state_d    = state_q;
        hp_d       = hp_q;
        ifr_d      = ifr_q;
        blinkCnt_d = blinkCnt_q;
        blink_d    = blink_q;
        ack_d      = 1'b0;
`ifdef HP_REGEN_EN
        regen_d    = regen_q;
`endif
        case (state_q)
            ALIVE: begin
                if (hit) begin
                    hp_d  = hitResult;
                    ack_d = 1'b1;
`ifdef HP_REGEN_EN
                    regen_d = '0;
`endif
                    if (hitResult == 6'd0) begin
                        state_d = DEAD;
                    end else begin
                        state_d    = INVULN;
                        ifr_d      = IFR_LOAD;
                        blinkCnt_d = 2'd0;
                        blink_d    = 1'b0;
                    end
                end else if (heal) begin
                    hp_d = healSat;
`ifdef HP_REGEN_EN
                    regen_d = '0;
`endif
                end
`ifdef HP_REGEN_EN
                else if (frame_tick && hp_q != 6'd0 && hp_q < HP_FULL) begin
                    if (regen_q == REGEN_LAST) begin
                        hp_d    = hp_q + 6'd1;
                        regen_d = '0;
                    end else begin
                        regen_d = regen_q + 16'd1;
                    end
                end
`endif
            end
            INVULN: begin
                if (heal) begin
                    hp_d = healSat;
`ifdef HP_REGEN_EN
                    regen_d = '0;
`endif
                end
                if (frame_tick) begin
                    ifr_d = ifr_q - 8'd1;
                    if (ifr_q == 8'd1) begin
                        state_d    = ALIVE;
                        blinkCnt_d = 2'd0;
                        blink_d    = 1'b0;
                    end else begin
                        blinkCnt_d = blinkCnt_q + 2'd1;
                        if (blinkCnt_q == 2'd3) begin
                            blink_d = ~blink_q;
                        end
                    end
                end
            end
            DEAD: begin
                if (revive) begin
                    state_d    = ALIVE;
                    hp_d       = HP_FULL;
                    blinkCnt_d = 2'd0;
                    blink_d    = 1'b0;
`ifdef HP_REGEN_EN
                    regen_d = '0;
`endif
                end
            end
            default: state_d = ALIVE;
        endcase
    end

    always_ff @(posedge Pclk or posedge rst) begin
        if (rst) begin
            state_q    <= ALIVE;
            hp_q       <= HP_FULL;
            ifr_q      <= 8'd0;
            blinkCnt_q <= 2'd0;
            blink_q    <= 1'b0;
            ack_q      <= 1'b0;
            fill_q     <= FILL_FULL;
        end else begin
            state_q    <= state_d;
            hp_q       <= hp_d;
            ifr_q      <= ifr_d;
            blinkCnt_q <= blinkCnt_d;
            blink_q    <= blink_d;
            ack_q      <= ack_d;
            fill_q     <= 10'(BAR_X0 + (32'(hp_q) * BAR_W) / HP_MAX);
        end
    end

`ifdef HP_REGEN_EN
    always_ff @(posedge Pclk or posedge rst) begin
        if (rst) begin
            regen_q <= '0;
        end else begin
            regen_q <= regen_d;
        end
    end
`endif

    assign hp        = hp_q;
    assign hp_fill_x = fill_q;
    assign hit_ack   = ack_q;
    assign invuln    = (state_q == INVULN);
    assign dead      = (state_q == DEAD);
    assign blink     = blink_q;

endmodule

// File: tb/tb_hp_tracker.sv
// Directed bench for hp_tracker: a vector table for hit/heal/revive/iframe
// behaviour plus hand sequences for blink, reset mid-INVULN/ack and regen.
module tb_hp_tracker;

   logic       Pclk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick = 1'b0;
   logic       hit = 1'b0;
   logic [4:0] hit_dmg = '0;
   logic       heal = 1'b0;
   logic [4:0] heal_amt = '0;
   logic       revive = 1'b0;
   logic [5:0] hp;
   logic [9:0] hp_fill_x;
   logic       hit_ack;
   logic       invuln;
   logic       blink;
   logic       dead;

   int checks = 0;
   int errors = 0;

   hp_tracker dut (
      .Pclk(Pclk), .rst(rst), .frame_tick(frame_tick),
      .hit(hit), .hit_dmg(hit_dmg), .heal(heal), .heal_amt(heal_amt),
      .revive(revive), .hp(hp), .hp_fill_x(hp_fill_x), .hit_ack(hit_ack),
      .invuln(invuln), .blink(blink), .dead(dead)
   );

   // 25 MHz pixel clock
   always #20 Pclk = ~Pclk;

   typedef struct {
      logic       hit;
      logic [4:0] dmg;
      logic       heal;
      logic [4:0] amt;
      logic       revive;
      logic       tick;
      int         reps;
      logic [5:0] expHp;
      logic       expAck;
      logic       expInv;
      logic       expDead;
      logic [9:0] expFill;
   } vec_t;

   vec_t vecs [26];

   // One comparison; prints a FAIL line when actual differs from expected
   task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drives one input set for reps cycles, ending on a negedge sample point
   task automatic applyStimulus(input logic h, input logic [4:0] d, input logic he,
                                input logic [4:0] a, input logic rv, input logic t, input int reps);
      hit = h; hit_dmg = d; heal = he; heal_amt = a; revive = rv; frame_tick = t;
      for (int r = 0; r < reps; r++) begin
         @(posedge Pclk);
         @(negedge Pclk);
      end
      hit = 1'b0; heal = 1'b0; revive = 1'b0; frame_tick = 1'b0;
   endtask

   initial begin
      // hit dmg heal amt rev tick reps | hp ack inv dead fill
      vecs[0]  = '{0, 0, 0, 0, 0, 0, 1,   20, 0, 0, 0, 150};
      vecs[1]  = '{1, 5, 0, 0, 0, 0, 1,   15, 1, 1, 0, 150};
      vecs[2]  = '{1, 7, 0, 0, 0, 0, 1,   15, 0, 1, 0, 125};
      vecs[3]  = '{1, 7, 1, 2, 0, 0, 1,   17, 0, 1, 0, 125};
      vecs[4]  = '{1, 7, 0, 0, 0, 1, 59,  17, 0, 1, 0, 135};
      vecs[5]  = '{1, 7, 0, 0, 0, 1, 1,   17, 0, 0, 0, 135};
      vecs[6]  = '{1, 7, 0, 0, 0, 0, 1,   10, 1, 1, 0, 135};
      vecs[7]  = '{0, 0, 0, 0, 0, 1, 60,  10, 0, 0, 0, 100};
      vecs[8]  = '{0, 0, 1, 5, 0, 0, 1,   15, 0, 0, 0, 100};
      vecs[9]  = '{0, 0, 1, 10, 0, 0, 1,  20, 0, 0, 0, 125};
      vecs[10] = '{1, 4, 1, 10, 0, 0, 1,  16, 1, 1, 0, 150};
      vecs[11] = '{0, 0, 1, 31, 0, 0, 1,  20, 0, 1, 0, 130};
      vecs[12] = '{0, 0, 0, 0, 0, 1, 60,  20, 0, 0, 0, 150};
      vecs[13] = '{1, 17, 0, 0, 0, 0, 1,  3, 1, 1, 0, 150};
      vecs[14] = '{0, 0, 0, 0, 0, 1, 60,  3, 0, 0, 0, 65};
      vecs[15] = '{1, 9, 0, 0, 0, 0, 1,   0, 1, 0, 1, 65};
      vecs[16] = '{0, 0, 1, 5, 0, 0, 1,   0, 0, 0, 1, 50};
      vecs[17] = '{1, 5, 0, 0, 0, 0, 1,   0, 0, 0, 1, 50};
      vecs[18] = '{0, 0, 0, 0, 1, 0, 1,   20, 0, 0, 0, 50};
      vecs[19] = '{0, 0, 0, 0, 0, 0, 1,   20, 0, 0, 0, 150};
      vecs[20] = '{1, 0, 0, 0, 0, 0, 1,   20, 1, 1, 0, 150};
      vecs[21] = '{0, 0, 0, 0, 0, 1, 60,  20, 0, 0, 0, 150};
      vecs[22] = '{1, 2, 0, 0, 0, 1, 1,   18, 1, 1, 0, 150};
      vecs[23] = '{0, 0, 0, 0, 0, 1, 59,  18, 0, 1, 0, 140};
      vecs[24] = '{0, 0, 0, 0, 0, 1, 1,   18, 0, 0, 0, 140};
      vecs[25] = '{0, 0, 1, 10, 0, 0, 1,  20, 0, 0, 0, 140};

      // Reset values
      repeat (2) @(negedge Pclk);
      checkOutput("reset_hp", 10'(hp), 10'd20);
      checkOutput("reset_fill", hp_fill_x, 10'd150);
      checkOutput("reset_ack", 10'(hit_ack), 10'd0);
      checkOutput("reset_inv", 10'(invuln), 10'd0);
      checkOutput("reset_dead", 10'(dead), 10'd0);
      rst = 1'b0;

      // Table-driven main function
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].hit, vecs[i].dmg, vecs[i].heal, vecs[i].amt,
                       vecs[i].revive, vecs[i].tick, vecs[i].reps);
         checkOutput($sformatf("v%0d_hp", i), 10'(hp), 10'(vecs[i].expHp));
         checkOutput($sformatf("v%0d_ack", i), 10'(hit_ack), 10'(vecs[i].expAck));
         checkOutput($sformatf("v%0d_inv", i), 10'(invuln), 10'(vecs[i].expInv));
         checkOutput($sformatf("v%0d_dead", i), 10'(dead), 10'(vecs[i].expDead));
         checkOutput($sformatf("v%0d_fill", i), hp_fill_x, vecs[i].expFill);
      end

      // Blink toggles every 4 ticks inside INVULN
      applyStimulus(1, 1, 0, 0, 0, 0, 1);
      checkOutput("blink_hp", 10'(hp), 10'd19);
      checkOutput("blink_start", 10'(blink), 10'd0);
      applyStimulus(0, 0, 0, 0, 0, 1, 3);
      checkOutput("blink_t3", 10'(blink), 10'd0);
      applyStimulus(0, 0, 0, 0, 0, 1, 1);
      checkOutput("blink_t4", 10'(blink), 10'd1);
      applyStimulus(0, 0, 0, 0, 0, 1, 3);
      checkOutput("blink_t7", 10'(blink), 10'd1);
      applyStimulus(0, 0, 0, 0, 0, 1, 1);
      checkOutput("blink_t8", 10'(blink), 10'd0);
      applyStimulus(0, 0, 0, 0, 0, 1, 4);
      checkOutput("blink_t12", 10'(blink), 10'd1);

      // Async reset mid-INVULN
      rst = 1'b1;
      #1;
      checkOutput("rstinv_hp", 10'(hp), 10'd20);
      checkOutput("rstinv_inv", 10'(invuln), 10'd0);
      checkOutput("rstinv_blink", 10'(blink), 10'd0);
      checkOutput("rstinv_fill", hp_fill_x, 10'd150);
      @(negedge Pclk);
      rst = 1'b0;

      // Async reset while an ack is pending
      hit = 1'b1; hit_dmg = 5'd3;
      @(posedge Pclk);
      #1;
      checkOutput("rstack_pre_ack", 10'(hit_ack), 10'd1);
      checkOutput("rstack_pre_hp", 10'(hp), 10'd17);
      rst = 1'b1;
      #1;
      hit = 1'b0;
      checkOutput("rstack_ack", 10'(hit_ack), 10'd0);
      checkOutput("rstack_hp", 10'(hp), 10'd20);
      checkOutput("rstack_inv", 10'(invuln), 10'd0);
      @(negedge Pclk);
      rst = 1'b0;

      // Regeneration from hp=10 in ALIVE over 240 frame ticks
      applyStimulus(1, 10, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 60);
      checkOutput("regen_start_hp", 10'(hp), 10'd10);
      checkOutput("regen_start_inv", 10'(invuln), 10'd0);
      applyStimulus(0, 0, 0, 0, 0, 1, 240);
`ifdef HP_REGEN_EN
      checkOutput("regen_hp", 10'(hp), 10'd12);
`else
      checkOutput("regen_hp", 10'(hp), 10'd10);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
